// File: rtl/dvp_pkg.sv
// dvp_pkg: shared state encoding, default DVP timing and the colour-bar palette
package dvp_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT} dvp_state_t;
    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_H_BLANK     = 288;
    localparam int DEF_VSYNC_LINES = 3;
    localparam int DEF_V_BACK      = 17;
    localparam int DEF_V_FRONT     = 10;
    localparam int BAR_WIDTH       = 80;
    localparam logic [15:0] BAR_COLOURS [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };
    function automatic logic [15:0] bar_colour(input logic [14:0] x);
        return BAR_COLOURS[(x >= 15'(7 * BAR_WIDTH)) ? 3'd7 : 3'(x / 15'(BAR_WIDTH))];
    endfunction
endpackage

// File: rtl/dvp_timing_gen.sv
// dvp_timing_gen: frame FSM with line/column counters; its position is the cycle
// the top level registers onto the outputs at the next edge
module dvp_timing_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int V_FRONT     = DEF_V_FRONT
) (
    input  logic        p_clock,
    input  logic        rst,
    input  logic        enable,
    output dvp_state_t  state,
    output logic [14:0] x,
    output logic [15:0] y,
    output logic        phase
);
    localparam logic [15:0] LAST_COL = 16'(2 * H_ACTIVE + H_BLANK - 1);
    logic [15:0] col;
    logic [15:0] last_line;
    logic        eol;
    logic        eos;
    always_comb begin
        last_line = state == ST_VSYNC  ? 16'(VSYNC_LINES - 1) :
                    state == ST_VBACK  ? 16'(V_BACK - 1) :
                    state == ST_ACTIVE ? 16'(V_ACTIVE - 1) : 16'(V_FRONT - 1);
    end
    assign eol   = col == LAST_COL;
    assign eos   = eol && y == last_line;
    assign x     = col[15:1];
    assign phase = col[0];
    always_ff @(posedge p_clock) begin
        if (rst) begin
            state <= ST_IDLE;
            col   <= '0;
            y     <= '0;
        end else if (state == ST_IDLE) begin
            // the top emits vsync column 0 straight from IDLE, so resume at column 1
            col <= enable ? 16'd1 : 16'd0;
            y   <= '0;
            if (enable) state <= ST_VSYNC;
        end else begin
            col <= eol ? 16'd0 : col + 16'd1;
            if (eol) y <= eos ? 16'd0 : y + 16'd1;
            if (eos) state <= state == ST_VSYNC  ? ST_VBACK :
                              state == ST_VBACK  ? ST_ACTIVE :
                              state == ST_ACTIVE ? ST_VFRONT :
                              enable             ? ST_VSYNC : ST_IDLE;
        end
    end
endmodule

// File: rtl/dvp_frame_tx.sv
// dvp_frame_tx: DVP frame transmitter; RGB565 pixels from a stream or colour bars
// sent high byte first under vsync/href framing
module dvp_frame_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int V_FRONT     = DEF_V_FRONT
) (
    input  logic        p_clock,
    input  logic        rst,
    input  logic        enable,
    input  logic        pattern_sel,
    input  logic [15:0] s_pixel_data,
    input  logic        s_pixel_valid,
    output logic        s_pixel_ready,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  p_data,
    output logic        frame_start,
    output logic        underflow
);
    dvp_state_t  state;
    logic [14:0] x;
    logic [15:0] y;
    logic        phase;
    logic        pat_q;
    logic [15:0] pix_q;
    logic [15:0] cur_pix;
    logic        active;
    logic        fs_next;
    dvp_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
        .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
    ) u_timing (
        .p_clock(p_clock), .rst(rst), .enable(enable),
        .state(state), .x(x), .y(y), .phase(phase)
    );
    assign active        = state == ST_ACTIVE && x < 15'(H_ACTIVE);
    assign fs_next       = (state == ST_IDLE && enable) || (state == ST_VSYNC && y == 16'd0 && x == 15'd0 && !phase);
    assign s_pixel_ready = active && !phase && !pat_q;
    // a missing source pixel is sent as black rather than stalling the line
    assign cur_pix       = pat_q ? bar_colour(x) : s_pixel_valid ? s_pixel_data : 16'h0000;
    always_ff @(posedge p_clock) begin
        if (rst) begin
            vsync       <= 1'b0;
            href        <= 1'b0;
            p_data      <= 8'h00;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            pat_q       <= 1'b0;
            pix_q       <= 16'h0000;
        end else begin
            vsync       <= state == ST_VSYNC || (state == ST_IDLE && enable);
            href        <= active;
            p_data      <= !active ? 8'h00 : phase ? pix_q[7:0] : cur_pix[15:8];
            frame_start <= fs_next;
            underflow   <= (underflow && !fs_next) || (s_pixel_ready && !s_pixel_valid);
            if (active && !phase) pix_q <= cur_pix;
            if (fs_next) pat_q <= pattern_sel;
        end
    end
endmodule

// File: tb/tb_dvp_frame_tx.sv
// tb_dvp_frame_tx: directed scoreboard bench for dvp_frame_tx with a shortened frame
module tb_dvp_frame_tx;
    localparam int HA    = 640;
    localparam int VA    = 3;
    localparam int HB    = 8;
    localparam int VSL   = 2;
    localparam int VB    = 1;
    localparam int VF    = 1;
    localparam int LINE  = 2 * HA + HB;
    localparam int FRAME = (VSL + VB + VA + VF) * LINE;
    localparam logic [15:0] BARS [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    logic        p_clock = 1'b0;
    logic        rst, enable, pattern_sel, s_pixel_valid;
    logic [15:0] s_pixel_data;
    logic        s_pixel_ready, vsync, href, frame_start, underflow;
    logic [7:0]  p_data;

    dvp_frame_tx #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .VSYNC_LINES(VSL), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .p_clock(p_clock), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .s_pixel_data(s_pixel_data), .s_pixel_valid(s_pixel_valid), .s_pixel_ready(s_pixel_ready),
        .vsync(vsync), .href(href), .p_data(p_data), .frame_start(frame_start), .underflow(underflow)
    );

    always #5 p_clock = ~p_clock;

    int tests = 0, fails = 0;
    int cyc = 0, last_fs_cyc = 0, last_gap = 0, fs_total = 0;
    int href_run = 0, href_cnt = 0, vs_run = 0, hs_cnt = 0, rdy_idx = 0;
    int last_hs = 0, last_hrefs = 0;
    logic last_uf = 1'b0, uf_prev = 1'b0, pat_frame = 1'b0, fs_seen = 1'b0, drop_mode = 1'b0;
    logic [15:0] src_cnt = 16'h0001;
    logic [7:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    // one clock: check outputs at the falling edge, then drive the source for the next edge
    task automatic tick();
        logic [15:0] px;
        logic [15:0] c;
        @(negedge p_clock);
        cyc++;
        fs_seen = frame_start;
        if (rst) begin
            sb.delete();
            href_run = 0;
            vs_run   = 0;
            href_cnt = 0;
        end else begin
            if (frame_start) begin
                chk("fs_with_vsync", vsync, 1);
                fs_total++;
                last_gap    = cyc - last_fs_cyc;
                last_fs_cyc = cyc;
                last_hs     = hs_cnt;
                last_hrefs  = href_cnt;
                last_uf     = uf_prev;
                hs_cnt      = 0;
                href_cnt    = 0;
                rdy_idx     = 0;
                pat_frame   = pattern_sel;
            end
            if (href) begin
                if (href_run == 0) begin
                    href_cnt++;
                    if (pat_frame) for (int i = 0; i < HA; i++) begin
                        c = BARS[i / 80];
                        sb.push_back(c[15:8]);
                        sb.push_back(c[7:0]);
                    end
                end
                href_run++;
                if (sb.size() == 0) timeout("sb_empty");
                else chk("href_byte", p_data, sb.pop_front());
            end else begin
                if (href_run != 0) chk("href_len", href_run, 2 * HA);
                href_run = 0;
                chk("blank_data", p_data, 0);
            end
            if (vsync) vs_run++;
            else begin
                if (vs_run != 0) chk("vsync_len", vs_run, VSL * LINE);
                vs_run = 0;
            end
            if (pat_frame) chk("pattern_ready", s_pixel_ready, 0);
        end
        uf_prev       = underflow;
        s_pixel_valid = !(drop_mode && rdy_idx == 5);
        s_pixel_data  = src_cnt;
        if (s_pixel_ready) begin
            px = s_pixel_valid ? src_cnt : 16'h0000;
            sb.push_back(px[15:8]);
            sb.push_back(px[7:0]);
            if (s_pixel_valid) begin
                src_cnt++;
                hs_cnt++;
            end
            rdy_idx++;
        end
    endtask

    task automatic wait_fs();
        for (int i = 0; i < FRAME + 2 * LINE; i++) begin
            tick();
            if (fs_seen) return;
        end
        timeout("wait_frame_start");
    endtask

    task automatic wait_href(input int n);
        for (int i = 0; i < FRAME + 2 * LINE; i++) begin
            tick();
            if (href === 1'b1 && href_run == 1 && href_cnt == n) return;
        end
        timeout("wait_href");
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_vsync"}, vsync, 0);
        chk({tag, "_href"}, href, 0);
        chk({tag, "_p_data"}, p_data, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_ready"}, s_pixel_ready, 0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; pattern_sel = 1'b0;
        s_pixel_valid = 1'b0; s_pixel_data = 16'h0000;
        repeat (3) tick();
        chk_quiet("reset");
        chk("reset_underflow", underflow, 0);
        rst = 1'b0;
        repeat (4) tick();
        chk("idle_no_frame", fs_total, 0);
        chk_quiet("idle");
        // frame 1: colour bars; pattern_sel is dropped right after start and must not matter
        enable = 1'b1; pattern_sel = 1'b1;
        tick();
        chk("start_vsync", vsync, 1);
        chk("start_fs", frame_start, 1);
        pattern_sel = 1'b0;
        wait_href(1);
        chk("bar_x0_hi", p_data, 8'hFF);
        tick();
        chk("bar_x0_lo", p_data, 8'hFF);
        repeat (159) tick();
        chk("bar_x80_hi", p_data, 8'hFF);
        tick();
        chk("bar_x80_lo", p_data, 8'hE0);
        repeat (959) tick();
        chk("bar_x560_hi", p_data, 8'h00);
        tick();
        chk("bar_x560_lo", p_data, 8'h00);
        // frame 2: external stream counting from 1
        wait_fs();
        chk("f1_gap", last_gap, FRAME);
        chk("f1_hrefs", last_hrefs, VA);
        chk("f1_handshakes", last_hs, 0);
        wait_href(1);
        chk("stream_b0", p_data, 8'h00);
        tick();
        chk("stream_b1", p_data, 8'h01);
        tick();
        chk("stream_b2", p_data, 8'h00);
        tick();
        chk("stream_b3", p_data, 8'h02);
        // frame 3: pixel 5 of line 0 missing, enable dropped at line 1
        wait_fs();
        chk("f2_gap", last_gap, FRAME);
        chk("f2_hrefs", last_hrefs, VA);
        chk("f2_handshakes", last_hs, HA * VA);
        chk("f2_underflow", last_uf, 0);
        drop_mode = 1'b1;
        wait_href(2);
        chk("underflow_set", underflow, 1);
        enable = 1'b0;
        repeat (FRAME) tick();
        chk("f3_no_restart", fs_total, 3);
        chk("f3_hrefs", href_cnt, VA);
        chk("f3_handshakes", hs_cnt, HA * VA - 1);
        chk("underflow_sticky", underflow, 1);
        chk_quiet("after_stop");
        // frame 4: restart clears underflow, then reset lands mid-href on line 1
        drop_mode = 1'b0; enable = 1'b1; pattern_sel = 1'b0;
        tick();
        chk("restart_fs", frame_start, 1);
        chk("underflow_cleared", underflow, 0);
        chk("f3_underflow_held", last_uf, 1);
        wait_href(2);
        repeat (600) tick();
        chk("mid_href", href, 1);
        rst = 1'b1;
        tick();
        chk_quiet("mid_reset");
        chk("mid_reset_underflow", underflow, 0);
        rst = 1'b0; pattern_sel = 1'b1;
        tick();
        chk("post_reset_vsync", vsync, 1);
        chk("post_reset_fs", frame_start, 1);
        enable = 1'b0;
        repeat (FRAME + 20) tick();
        chk("f5_hrefs", href_cnt, VA);
        chk("f5_frames", fs_total, 5);
        chk("f5_underflow", underflow, 0);
        chk_quiet("final");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
